// File: rtl/aftab_restoring_divider.sv
// aftab_restoring_divider: signed restoring divider producing one quotient bit per cycle.
// Results are corrected for sign in FIX and hold until the next operation updates them.
module aftab_restoring_divider #(
  parameter int size = 33
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [size-1:0] dividend,
  input  logic [size-1:0] divisor,
  output logic            done,
  output logic            busy,
  output logic [size-1:0] quotient,
  output logic [size-1:0] remainder,
  output logic            dbz
);
  localparam int CW = $clog2(size + 1);
  typedef enum logic [2:0] {IDLE, LOAD, DIVIDE, FIX, DONE} state_t;
  state_t state_q, state_d;
  logic [size-1:0] a_q, a_d, b_q, b_d, qr_q, qr_d, dm_q, dm_d, quot_q, quot_d, rem_q, rem_d;
  logic [size:0] pr_q, pr_d;
  logic [size+1:0] diff;
  logic [CW-1:0] cnt_q, cnt_d;
  logic qneg_q, qneg_d, rneg_q, rneg_d, dbz_q, dbz_d, done_q, done_d, busy_q, busy_d;
  // Trial subtraction of the shifted partial remainder; the top bit is the borrow.
  assign diff = {pr_q, qr_q[size-1]} - {2'b0, dm_q};
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    qr_d    = qr_q;
    dm_d    = dm_q;
    pr_d    = pr_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    done_d  = state_q == DONE;
    busy_d  = done_q ? 1'b0 : busy_q;
    case (state_q)
      IDLE: if (start && !busy_q) begin
        a_d     = dividend;
        b_d     = divisor;
        busy_d  = 1'b1;
        state_d = LOAD;
      end
      LOAD: begin
        qr_d    = a_q[size-1] ? -a_q : a_q;
        dm_d    = b_q[size-1] ? -b_q : b_q;
        qneg_d  = a_q[size-1] ^ b_q[size-1];
        rneg_d  = a_q[size-1];
        dbz_d   = b_q == '0;
        pr_d    = '0;
        cnt_d   = CW'(size);
        quot_d  = b_q == '0 ? '1 : quot_q;
        rem_d   = b_q == '0 ? a_q : rem_q;
        state_d = b_q == '0 ? DONE : DIVIDE;
      end
      DIVIDE: begin
        pr_d    = diff[size+1] ? {pr_q[size-1:0], qr_q[size-1]} : diff[size:0];
        qr_d    = {qr_q[size-2:0], ~diff[size+1]};
        cnt_d   = cnt_q - CW'(1);
        state_d = cnt_q == CW'(1) ? FIX : DIVIDE;
      end
      FIX: begin
        quot_d  = qneg_q ? -qr_q : qr_q;
        rem_d   = rneg_q ? -pr_q[size-1:0] : pr_q[size-1:0];
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      qr_q    <= '0;
      dm_q    <= '0;
      pr_q    <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      qr_q    <= qr_d;
      dm_q    <= dm_d;
      pr_q    <= pr_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end
  assign done      = done_q;
  assign busy      = busy_q;
  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign dbz       = dbz_q;
endmodule

// File: tb/tb_aftab_restoring_divider.sv
// tb_aftab_restoring_divider: directed vectors with a queue-based scoreboard for the divider.
module tb_aftab_restoring_divider;
  localparam int N = 33;
  logic clk = 0, rst = 0, start = 0;
  logic [N-1:0] dividend = '0, divisor = '0;
  logic done, busy, dbz;
  logic [N-1:0] quotient, remainder;
  int cyc = 0, errors = 0, checks = 0;
  typedef struct {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dbz;
    int           cyc;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e, drv_e;

  aftab_restoring_divider #(.size(N)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .done(done), .busy(busy), .quotient(quotient), .remainder(remainder), .dbz(dbz)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) if (rst && done) begin
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_done: got done=1 expected no pulse (cycle %0d)", cyc);
    end else begin
      mon_e = sb.pop_front();
      chk("quotient", quotient, mon_e.q);
      chk("remainder", remainder, mon_e.r);
      chk("dbz", N'(dbz), N'(mon_e.dbz));
      chk("latency", N'(cyc), N'(mon_e.cyc));
    end
  end

  // Called just after a falling edge; returns after the falling edge following acceptance.
  task automatic issue(input logic [N-1:0] a, b, eq, er, input logic ed);
    dividend = a;
    divisor  = b;
    start    = 1;
    @(posedge clk);
    #1;
    drv_e = '{q: eq, r: er, dbz: ed, cyc: cyc + (b == '0 ? 2 : N + 3)};
    sb.push_back(drv_e);
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done within %0d cycles expected done", n);
    end
  endtask

  task automatic run(input logic [N-1:0] a, b, eq, er, input logic ed);
    issue(a, b, eq, er, ed);
    wait_done();
    @(negedge clk);
  endtask

  initial begin
    int bad, n;
    dividend = N'(5);
    divisor  = N'(1);
    start    = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", N'(busy), '0);
    chk("rst_done", N'(done), '0);
    chk("rst_quotient", quotient, '0);
    chk("rst_remainder", remainder, '0);
    chk("rst_dbz", N'(dbz), '0);
    start = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    run(N'(50), N'(-3), N'(-16), N'(2), 1'b0);
    chk("q_50_m3_hold", quotient, 33'h1_FFFF_FFF0);
    run(N'(-7), N'(2), N'(-3), N'(-1), 1'b0);
    run(N'(7), N'(0), 33'h1_FFFF_FFFF, N'(7), 1'b1);
    run(N'(-8), N'(0), 33'h1_FFFF_FFFF, N'(-8), 1'b1);
    run(33'h1_0000_0000, N'(-1), 33'h1_0000_0000, N'(0), 1'b0);
    run(33'h1_0000_0000, N'(1), 33'h1_0000_0000, N'(0), 1'b0);
    run(33'h0_FFFF_FFFF, N'(1), 33'h0_FFFF_FFFF, N'(0), 1'b0);
    run(N'(0), N'(5), N'(0), N'(0), 1'b0);
    run(N'(5), N'(9), N'(0), N'(5), 1'b0);
    run(N'(100), N'(-7), N'(-14), N'(2), 1'b0);
    run(N'(-100), N'(7), N'(-14), N'(-2), 1'b0);
    // start pulsed at edge k+10 with new operands must be ignored
    issue(N'(50), N'(-3), N'(-16), N'(2), 1'b0);
    repeat (9) @(negedge clk);
    dividend = N'(1000);
    divisor  = N'(1);
    start    = 1;
    @(negedge clk);
    start = 0;
    bad = 0;
    n = 0;
    while (!done && n < 100) begin
      if (!busy) bad++;
      @(negedge clk);
      n++;
    end
    chk("busy_held", N'(bad), '0);
    chk("busy_at_done", N'(busy), N'(1));
    @(negedge clk);
    // reset at edge k+20 aborts the divide with no done pulse
    issue(N'(100), N'(3), N'(33), N'(1), 1'b0);
    repeat (19) @(negedge clk);
    @(posedge clk);
    #2 rst = 0;
    #1;
    chk("abort_busy", N'(busy), '0);
    chk("abort_done", N'(done), '0);
    chk("abort_quotient", quotient, '0);
    chk("abort_remainder", remainder, '0);
    chk("abort_dbz", N'(dbz), '0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1;
    repeat (40) @(negedge clk);
    run(N'(100), N'(7), N'(14), N'(2), 1'b0);
    // back-to-back: start held from the done cycle is taken on the following edge
    issue(N'(-100), N'(-7), N'(14), N'(-2), 1'b0);
    wait_done();
    dividend = N'(100);
    divisor  = N'(-7);
    start    = 1;
    @(posedge clk);
    #1;
    chk("b2b_busy_fell", N'(busy), '0);
    chk("b2b_hold_q", quotient, N'(14));
    @(posedge clk);
    #1;
    drv_e = '{q: N'(-14), r: N'(2), dbz: 1'b0, cyc: cyc + N + 3};
    sb.push_back(drv_e);
    chk("b2b_busy_rose", N'(busy), N'(1));
    @(negedge clk);
    start = 0;
    repeat (5) @(negedge clk);
    chk("b2b_hold_q_busy", quotient, N'(14));
    chk("b2b_hold_r_busy", remainder, N'(-2));
    wait_done();
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", N'(sb.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/aftab_restoring_divider.md
AFTAB_RESTORING_DIVIDER -- requirements
Module: aftab_restoring_divider

Interface
REQ-001 SHALL have parameter: size, default 33, operand/result width in bits (two's complement).
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port: start  input  1  begin operation; sampled only in IDLE.
REQ-005 SHALL have port: dividend  input  size  signed dividend, sampled with start.
REQ-006 SHALL have port: divisor  input  size  signed divisor, sampled with start.
REQ-007 SHALL have port: done  output  1  one-cycle pulse, results valid.
REQ-008 SHALL have port: busy  output  1  high from the accepting edge until done falls.
REQ-009 SHALL have port: quotient  output  size  signed quotient, truncated toward zero.
REQ-010 SHALL have port: remainder  output  size  signed remainder, sign of dividend.
REQ-011 SHALL have port: dbz  output  1  divide-by-zero flag, valid with done.

Function
REQ-012 SHALL implement FSM states IDLE, LOAD, DIVIDE, FIX, DONE.
REQ-013 IDLE: start=1 at edge k SHALL register dividend/divisor, set busy, go to LOAD.
REQ-014 LOAD: SHALL form unsigned magnitudes of both operands and record signs (qneg = sign(dividend) XOR sign(divisor); rneg = sign(dividend)).
REQ-015 LOAD: divisor = 0 SHALL set dbz and go directly to DONE; otherwise clear dbz, clear partial remainder (size+1 bits), load counter = size, go to DIVIDE.
REQ-016 DIVIDE: each cycle SHALL shift {partial remainder, quotient register} left by 1, subtract divisor magnitude, keep result and set quotient LSB to 1 if non-negative, otherwise restore and set LSB 0; decrement counter.
REQ-017 DIVIDE SHALL last exactly size cycles, then go to FIX.
REQ-018 FIX: SHALL negate quotient magnitude if qneg and remainder magnitude if rneg (modulo 2^size), writing quotient and remainder outputs; go to DONE.
REQ-019 DONE: done SHALL be 1 for exactly one cycle; next state IDLE; busy falls with done.
REQ-020 Latency: nonzero divisor SHALL give done high in the cycle following edge k+size+3 (size=33: 36 edges); zero divisor SHALL give done in the cycle following edge k+2.
REQ-021 Divide by zero: quotient SHALL be all ones, remainder SHALL equal dividend, dbz = 1.
REQ-022 Overflow (dividend = -2^(size-1), divisor = -1): quotient SHALL equal dividend, remainder 0, dbz 0, no special state.
REQ-023 start while busy SHALL be ignored; operands SHALL not be resampled.
REQ-024 start high in the DONE cycle SHALL be ignored; start sampled in IDLE on the following edge SHALL be accepted (back-to-back gap of one cycle).
REQ-025 quotient, remainder, dbz SHALL hold their values from DONE until the next FIX/DONE update, including during later busy periods.

Reset
REQ-026 rst = 0 SHALL immediately force state IDLE, done 0, busy 0, dbz 0, quotient 0, remainder 0, counter 0, internal registers 0.
REQ-027 Reset asserted mid-operation SHALL abort without a done pulse; first start after release SHALL run a full, correct operation.
REQ-028 start SHALL be ignored while rst = 0.

Verification (size = 33)
REQ-029 dividend 50, divisor -3, start at edge k -> done at edge k+36, quotient -16 (33'h1_FFFF_FFF0), remainder 2, dbz 0.
REQ-030 dividend -7, divisor 2 -> quotient -3, remainder -1; dividend 7, divisor 0 -> done at k+2, quotient 33'h1_FFFF_FFFF, remainder 7, dbz 1.
REQ-031 dividend 33'h1_0000_0000, divisor -1 -> quotient 33'h1_0000_0000, remainder 0, dbz 0.
REQ-032 start pulsed again at k+10 with new operands -> ignored; results match first operands; busy continuously high.
REQ-033 rst low at k+20 of a divide -> busy, done, outputs 0 at once, no done pulse; then 100/7 -> quotient 14, remainder 2.
REQ-034 Two back-to-back divides (start in IDLE immediately after DONE) -> both done pulses correct, outputs hold between them.
